// File: rtl/fp_class_stream.sv
// fp_class_stream: streaming classifier/unpacker for a packed binary
// floating-point operand {sign, exp, sig}.
//
// Each accepted operand is classified as sNaN, qNaN, inf, zero, subnormal or
// normal. The operand is then unpacked into a sign, an unbiased signed
// exponent and a significand that carries an explicit leading bit.
// Subnormals are normalised by a binary-search leading-zero shifter that runs
// one stage per cycle. When daz is set, subnormals are reported as zero.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake; in_f and daz are captured on accept
//   in_f               packed operand {sign, exp[NEXP-1:0], sig[NSIG-1:0]}
//   daz                denormals-are-zero mode for this operand
//   out_valid/out_ready result handshake
//   out_sign           operand sign
//   out_exp            unbiased exponent (signed, NEXP+2 bits)
//   out_sig            significand with explicit leading bit (NSIG+1 bits)
//   out_snan..out_norm one-hot class flags
//   out_fclass         one-hot class mask: 0 -inf, 1 -norm, 2 -sub, 3 -zero,
//                      4 +zero, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN
//   state_dbg          current FSM state (0 IDLE, 1 NORM, 2 DONE)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and once out_valid is high
// every out_* signal holds until that transfer occurs.
module fp_class_stream #(
    parameter int NEXP       = 5,
    parameter int NSIG       = 10,
    parameter int BIAS       = (1 << (NEXP - 1)) - 1,
    parameter int EMIN       = 1 - BIAS,
    parameter int CLOG2_NSIG = $clog2(NSIG + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NEXP+NSIG:0]     in_f,
    input  logic                   daz,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic signed [NEXP+1:0] out_exp,
    output logic [NSIG:0]          out_sig,
    output logic                   out_snan,
    output logic                   out_qnan,
    output logic                   out_inf,
    output logic                   out_zero,
    output logic                   out_sub,
    output logic                   out_norm,
    output logic [9:0]             out_fclass,
    output logic [1:0]             state_dbg
);

    localparam int EW     = NEXP + 2;
    localparam int LAST_I = CLOG2_NSIG - 1;

    localparam logic signed [EW-1:0]  BIAS_X     = BIAS[EW-1:0];
    localparam logic signed [EW-1:0]  EMIN_X     = EMIN[EW-1:0];
    localparam logic [CLOG2_NSIG-1:0] LAST_STAGE = LAST_I[CLOG2_NSIG-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Operand field decode and classification (on the incoming operand)
    // ------------------------------------------------------------------
    logic            sign_in;
    logic [NEXP-1:0] exp_in;
    logic [NSIG-1:0] sig_in;
    logic            exp_ones, exp_zero, sig_zero, sig_msb;
    logic            c_snan, c_qnan, c_inf, c_zero, c_sub, c_norm;
    logic            need_norm;
    logic            accept;

    assign sign_in  = in_f[NEXP+NSIG];
    assign exp_in   = in_f[NEXP+NSIG-1:NSIG];
    assign sig_in   = in_f[NSIG-1:0];
    assign exp_ones = &exp_in;
    assign exp_zero = ~|exp_in;
    assign sig_zero = ~|sig_in;
    assign sig_msb  = sig_in[NSIG-1];

    assign c_qnan    = exp_ones & sig_msb;
    assign c_snan    = exp_ones & ~sig_zero & ~sig_msb;
    assign c_inf     = exp_ones & sig_zero;
    // A daz subnormal is reported as a zero of the same sign.
    assign c_zero    = exp_zero & (sig_zero | daz);
    assign c_sub     = exp_zero & ~sig_zero & ~daz;
    assign c_norm    = ~exp_ones & ~exp_zero;
    assign need_norm = c_sub;

    assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign state_dbg = state;

    function automatic logic [9:0] fclass_of(input logic s, input logic snan,
                                             input logic qnan, input logic inf,
                                             input logic zero, input logic sub,
                                             input logic norm);
        logic [9:0] m;
        m    = '0;
        m[0] = s & inf;
        m[1] = s & norm;
        m[2] = s & sub;
        m[3] = s & zero;
        m[4] = ~s & zero;
        m[5] = ~s & sub;
        m[6] = ~s & norm;
        m[7] = ~s & inf;
        m[8] = snan;
        m[9] = qnan;
        return m;
    endfunction

    // Exponent/significand for operands that need no normalisation.
    // NaN/inf keep the raw biased exponent; zeros (including daz
    // subnormals) come out as all-zero.
    logic signed [EW-1:0] d_exp;
    logic [NSIG:0]        d_sig;

    always_comb begin
        d_exp = $signed({2'b00, exp_in});
        d_sig = {1'b0, sig_in};
        if (c_norm) begin
            d_exp = $signed({2'b00, exp_in}) - BIAS_X;
            d_sig = {1'b1, sig_in};
        end else if (exp_zero) begin
            d_exp = '0;
            d_sig = '0;
        end
    end

    // ------------------------------------------------------------------
    // Binary-search normaliser: stage k tests the top 2^(CLOG2_NSIG-1-k)
    // bits of the working significand and shifts them out when all zero.
    // The shift amounts add up to the leading-zero count of the operand.
    // ------------------------------------------------------------------
    logic [NSIG:0]           work, work_nx;
    logic [CLOG2_NSIG-1:0]   cnt, cnt_nx, stage;
    int                      step;
    logic signed [EW-1:0]    norm_exp;

    always_comb begin
        step    = 1 << (CLOG2_NSIG - 1 - int'(stage));
        work_nx = work;
        cnt_nx  = cnt;
        if ((work >> (NSIG + 1 - step)) == '0) begin
            work_nx = work << step;
            cnt_nx  = cnt | step[CLOG2_NSIG-1:0];
        end
    end

    assign norm_exp = EMIN_X - $signed({{(EW - CLOG2_NSIG){1'b0}}, cnt_nx});

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_sig    <= '0;
            out_snan   <= 1'b0;
            out_qnan   <= 1'b0;
            out_inf    <= 1'b0;
            out_zero   <= 1'b0;
            out_sub    <= 1'b0;
            out_norm   <= 1'b0;
            out_fclass <= '0;
            work       <= '0;
            cnt        <= '0;
            stage      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Class and sign are final at accept; out_valid is
                        // low while normalising, so loading them early is
                        // invisible to the consumer.
                        out_sign   <= sign_in;
                        out_exp    <= d_exp;
                        out_sig    <= d_sig;
                        out_snan   <= c_snan;
                        out_qnan   <= c_qnan;
                        out_inf    <= c_inf;
                        out_zero   <= c_zero;
                        out_sub    <= c_sub;
                        out_norm   <= c_norm;
                        out_fclass <= fclass_of(sign_in, c_snan, c_qnan, c_inf,
                                                c_zero, c_sub, c_norm);
                        if (need_norm) begin
                            state     <= NORM;
                            out_valid <= 1'b0;
                            work      <= {1'b0, sig_in};
                            cnt       <= '0;
                            stage     <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                NORM: begin
                    work  <= work_nx;
                    cnt   <= cnt_nx;
                    stage <= stage + 1'b1;
                    if (stage == LAST_STAGE) begin
                        out_exp   <= norm_exp;
                        out_sig   <= work_nx;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_class_stream.sv
// Testbench for fp_class_stream (NEXP=5, NSIG=10): directed operands with
// hand-computed results. The driver queues the expected result and its
// expected arrival cycle; a negedge monitor checks arrival latency and pops
// and compares on every output transfer.
module tb_fp_class_stream;

    localparam int NEXP = 5;
    localparam int NSIG = 10;
    localparam int W    = NEXP + NSIG + 1;
    localparam int RW   = 1 + (NEXP + 2) + (NSIG + 1) + 6 + 10;

    // flag order {snan, qnan, inf, zero, sub, norm}
    localparam logic [5:0] F_SNAN = 6'b100000;
    localparam logic [5:0] F_QNAN = 6'b010000;
    localparam logic [5:0] F_INF  = 6'b001000;
    localparam logic [5:0] F_ZERO = 6'b000100;
    localparam logic [5:0] F_SUB  = 6'b000010;
    localparam logic [5:0] F_NORM = 6'b000001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [W-1:0]           in_f = '0;
    logic                   daz = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   out_sign;
    logic signed [NEXP+1:0] out_exp;
    logic [NSIG:0]          out_sig;
    logic                   out_snan, out_qnan, out_inf, out_zero, out_sub, out_norm;
    logic [9:0]             out_fclass;
    logic [1:0]             state_dbg;

    fp_class_stream #(.NEXP(NEXP), .NSIG(NSIG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f), .daz(daz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
        .out_snan(out_snan), .out_qnan(out_qnan), .out_inf(out_inf),
        .out_zero(out_zero), .out_sub(out_sub), .out_norm(out_norm),
        .out_fclass(out_fclass), .state_dbg(state_dbg)
    );

    logic [RW-1:0] act;
    assign act = {out_sign, out_exp, out_sig, out_snan, out_qnan, out_inf,
                  out_zero, out_sub, out_norm, out_fclass};

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];

    function automatic logic [RW-1:0] mk(input logic s, input int e,
                                         input logic [NSIG:0] sg,
                                         input logic [5:0] fl,
                                         input logic [9:0] fc);
        logic [NEXP+1:0] ev;
        ev = e[NEXP+1:0];
        return {s, ev, sg, fl, fc};
    endfunction

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", cyc, lat_q[0]);
                end
                if (out_ready) begin
                    check("result", act, exp_q.pop_front());
                    void'(lat_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] f, input logic d, input int lat,
                        input logic [RW-1:0] ev);
        int n;
        in_f     = f;
        daz      = d;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(ev);
            lat_q.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [RW-1:0] e_one;
    int vcount;

    initial begin
        e_one = mk(1'b0, 0, 11'h400, F_NORM, 10'h040);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", act, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // main classification stream, consumer always ready
        send(16'h3C00, 1'b0, 1, e_one);
        send(16'h0001, 1'b0, 5, mk(1'b0, -24, 11'h400, F_SUB, 10'h020));
        send(16'h0200, 1'b0, 5, mk(1'b0, -15, 11'h400, F_SUB, 10'h020));
        send(16'h8200, 1'b1, 1, mk(1'b1, 0, 11'h000, F_ZERO, 10'h008));
        drain();
        send(16'hFC00, 1'b0, 1, mk(1'b1, 31, 11'h000, F_INF, 10'h001));
        send(16'h7E00, 1'b0, 1, mk(1'b0, 31, 11'h200, F_QNAN, 10'h200));
        send(16'h7C01, 1'b0, 1, mk(1'b0, 31, 11'h001, F_SNAN, 10'h100));
        send(16'h0000, 1'b0, 1, mk(1'b0, 0, 11'h000, F_ZERO, 10'h010));
        send(16'h8000, 1'b0, 1, mk(1'b1, 0, 11'h000, F_ZERO, 10'h008));
        send(16'h7C00, 1'b0, 1, mk(1'b0, 31, 11'h000, F_INF, 10'h080));
        send(16'hC000, 1'b0, 1, mk(1'b1, 1, 11'h400, F_NORM, 10'h002));
        send(16'h0400, 1'b0, 1, mk(1'b0, -14, 11'h400, F_NORM, 10'h040));
        send(16'h7BFF, 1'b0, 1, mk(1'b0, 15, 11'h7FF, F_NORM, 10'h040));
        send(16'h3C00, 1'b1, 1, e_one);
        send(16'h83FF, 1'b0, 5, mk(1'b1, -15, 11'h7FE, F_SUB, 10'h004));
        send(16'h0010, 1'b0, 5, mk(1'b0, -20, 11'h400, F_SUB, 10'h020));
        // held on in_f with in_valid high throughout the preceding NORM
        send(16'h7C00, 1'b0, 1, mk(1'b0, 31, 11'h000, F_INF, 10'h080));
        drain();

        // in_f/daz wiggle during NORM must not disturb the result
        send(16'h0001, 1'b0, 5, mk(1'b0, -24, 11'h400, F_SUB, 10'h020));
        in_f = 16'hFFFF;
        daz  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drain();

        // consumer stall in DONE
        out_ready = 1'b0;
        send(16'h3C00, 1'b0, 1, e_one);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_data", act, e_one);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // reset in the middle of NORM
        send(16'h0001, 1'b0, 5, mk(1'b0, -24, 11'h400, F_SUB, 10'h020));
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("norm_rst_out_valid", out_valid, 0);
        check("norm_rst_in_ready", in_ready, 0);
        check("norm_rst_outputs", act, 0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_norm_rst", in_ready, 1);
        vcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("no_result_after_norm_rst", vcount, 0);
        @(posedge clk);
        #1;

        // reset while a result waits in DONE
        out_ready = 1'b0;
        send(16'h7E00, 1'b0, 1, mk(1'b0, 31, 11'h200, F_QNAN, 10'h200));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_outputs", act, 0);
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_done_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // traffic still works after the resets
        send(16'h0200, 1'b0, 5, mk(1'b0, -15, 11'h400, F_SUB, 10'h020));
        send(16'h3C00, 1'b0, 1, e_one);
        drain();

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
